// File: rtl/pwm_move_scheduler.sv
// Queued move-command dispatcher for the PWM channels: pops one command at a time
// and loads frequency, then pulse count, then fires a one-hot start for the target channel.
module pwm_move_scheduler #(
  parameter int NCH     = 16,
  parameter int DEPTH   = 8,
  parameter int ACK_TMO = 16,
  localparam int CW = $clog2(NCH),
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1,
  localparam int TW = $clog2(ACK_TMO + 1)
) (
  input  logic           clk100m,
  input  logic           rst_n,
  // cmd_valid/cmd_ready: a command transfers on any edge where both are high;
  // cmd_ready never depends on cmd_valid or on a pop in the same cycle.
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [CW-1:0]  cmd_ch,
  input  logic [31:0]    cmd_freq,
  input  logic [31:0]    cmd_pnum,
  input  logic [NCH-1:0] ch_busy,
  input  logic [NCH-1:0] limit_hit,
  input  logic           abort,
  output logic           freq_wr,
  output logic           pnum_wr,
  output logic [CW-1:0]  wr_ch,
  output logic [31:0]    wr_data,
  output logic [NCH-1:0] start_pulse,
  output logic [LW-1:0]  fifo_level,
  output logic [15:0]    drop_cnt,
  output logic           err_tmo,
  output logic           sched_idle,
  output logic [2:0]     dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_WR_FREQ, S_WR_PNUM, S_START, S_WAIT_ACK
  } state_t;

  logic [CW-1:0] ch_mem   [DEPTH];
  logic [31:0]   freq_mem [DEPTH];
  logic [31:0]   pnum_mem [DEPTH];

  state_t         state_q, state_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]  count_q, count_d;
  logic [CW-1:0]  lat_ch_q, lat_ch_d;
  logic [31:0]    lat_pnum_q, lat_pnum_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [15:0]    drop_q, drop_d;
  logic           err_q, err_d;
  logic           freq_wr_q, freq_wr_d, pnum_wr_q, pnum_wr_d;
  logic [CW-1:0]  wr_ch_q, wr_ch_d;
  logic [31:0]    wr_data_q, wr_data_d;
  logic [NCH-1:0] start_q, start_d;

  logic          full, empty, push, pop;
  logic [CW-1:0] head_ch;
  logic [31:0]   head_freq, head_pnum;

  assign full      = (count_q == LW'(DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign head_ch   = ch_mem[rd_ptr_q];
  assign head_freq = freq_mem[rd_ptr_q];
  assign head_pnum = pnum_mem[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    lat_ch_d   = lat_ch_q;
    lat_pnum_d = lat_pnum_q;
    tmo_d      = tmo_q;
    drop_d     = drop_q;
    err_d      = err_q;
    freq_wr_d  = 1'b0;
    pnum_wr_d  = 1'b0;
    wr_ch_d    = '0;
    wr_data_d  = '0;
    start_d    = '0;
    // Outputs are registered, so each strobe is computed on the transition into its state.
    case (state_q)
      S_IDLE: if (!empty) state_d = S_CHECK;
      S_CHECK: begin
        if (head_pnum == '0) begin
          pop     = 1'b1;
          state_d = S_IDLE;
        end else if (limit_hit[head_ch]) begin
          pop     = 1'b1;
          if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
          state_d = S_IDLE;
        end else if (!ch_busy[head_ch]) begin
          pop        = 1'b1;
          lat_ch_d   = head_ch;
          lat_pnum_d = head_pnum;
          freq_wr_d  = 1'b1;
          wr_ch_d    = head_ch;
          wr_data_d  = head_freq;
          state_d    = S_WR_FREQ;
        end
      end
      S_WR_FREQ: begin
        pnum_wr_d = 1'b1;
        wr_ch_d   = lat_ch_q;
        wr_data_d = lat_pnum_q;
        state_d   = S_WR_PNUM;
      end
      S_WR_PNUM: begin
        start_d = NCH'(1) << lat_ch_q;
        state_d = S_START;
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (ch_busy[lat_ch_q]) begin
          state_d = S_IDLE;
        end else if (tmo_q == TW'(ACK_TMO - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + LW'(1);
    if (pop && !push) count_d = count_q - LW'(1);

    // abort wins over everything; a start already on the wire is not recalled.
    if (abort) begin
      state_d   = S_IDLE;
      err_d     = 1'b0;
      freq_wr_d = 1'b0;
      pnum_wr_d = 1'b0;
      wr_ch_d   = '0;
      wr_data_d = '0;
      start_d   = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lat_ch_q   <= '0;
      lat_pnum_q <= '0;
      tmo_q      <= '0;
      drop_q     <= '0;
      err_q      <= 1'b0;
      freq_wr_q  <= 1'b0;
      pnum_wr_q  <= 1'b0;
      wr_ch_q    <= '0;
      wr_data_q  <= '0;
      start_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      lat_ch_q   <= lat_ch_d;
      lat_pnum_q <= lat_pnum_d;
      tmo_q      <= tmo_d;
      drop_q     <= drop_d;
      err_q      <= err_d;
      freq_wr_q  <= freq_wr_d;
      pnum_wr_q  <= pnum_wr_d;
      wr_ch_q    <= wr_ch_d;
      wr_data_q  <= wr_data_d;
      start_q    <= start_d;
    end
  end

  always_ff @(posedge clk100m) begin
    if (push) begin
      ch_mem[wr_ptr_q]   <= cmd_ch;
      freq_mem[wr_ptr_q] <= cmd_freq;
      pnum_mem[wr_ptr_q] <= cmd_pnum;
    end
  end

  assign freq_wr     = freq_wr_q;
  assign pnum_wr     = pnum_wr_q;
  assign wr_ch       = wr_ch_q;
  assign wr_data     = wr_data_q;
  assign start_pulse = start_q;
  assign fifo_level  = count_q;
  assign drop_cnt    = drop_q;
  assign err_tmo     = err_q;
  assign sched_idle  = (state_q == S_IDLE) && empty;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_move_scheduler.sv
// Bench for pwm_move_scheduler: directed moves, expected strobe sequence in a queue,
// a negedge monitor that pops and compares every strobe the DUT emits.
module tb_pwm_move_scheduler;
  localparam int NCH = 16;

  logic           clk100m = 1'b0;
  logic           rst_n   = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [3:0]     cmd_ch = '0;
  logic [31:0]    cmd_freq = '0, cmd_pnum = '0;
  logic [NCH-1:0] ch_busy, limit_hit = '0, force_busy = '0, model_busy = '0;
  logic           abort = 1'b0;
  logic           freq_wr, pnum_wr, err_tmo, sched_idle;
  logic [3:0]     wr_ch;
  logic [31:0]    wr_data;
  logic [NCH-1:0] start_pulse;
  logic [3:0]     fifo_level;
  logic [15:0]    drop_cnt;
  logic [2:0]     dbg_state;

  int total = 0;
  int bad   = 0;
  logic [37:0] exp_q[$];
  bit model_en = 1'b1;
  int dly[NCH];
  int hold[NCH];

  assign ch_busy = force_busy | model_busy;

  pwm_move_scheduler dut (
    .clk100m(clk100m), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_freq(cmd_freq), .cmd_pnum(cmd_pnum), .ch_busy(ch_busy),
    .limit_hit(limit_hit), .abort(abort), .freq_wr(freq_wr), .pnum_wr(pnum_wr),
    .wr_ch(wr_ch), .wr_data(wr_data), .start_pulse(start_pulse), .fifo_level(fifo_level),
    .drop_cnt(drop_cnt), .err_tmo(err_tmo), .sched_idle(sched_idle), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk100m = ~clk100m;

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  // Channel model: busy rises two negedges after a start is seen, holds for three.
  always @(negedge clk100m) begin
    for (int i = 0; i < NCH; i++) begin
      if (!rst_n || !model_en) begin
        dly[i] = 0;
        hold[i] = 0;
        model_busy[i] = 1'b0;
      end else if (start_pulse[i]) begin
        dly[i] = 2;
      end else if (dly[i] > 0) begin
        dly[i]--;
        if (dly[i] == 0) begin
          model_busy[i] = 1'b1;
          hold[i] = 3;
        end
      end else if (hold[i] > 0) begin
        hold[i]--;
        if (hold[i] == 0) model_busy[i] = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk100m) begin : mon
    int n;
    logic [37:0] got;
    n = int'(freq_wr) + int'(pnum_wr) + int'(start_pulse != '0);
    if (n == 0) begin
      check("idle_bus", {28'd0, wr_ch, wr_data}, 64'd0);
    end else begin
      check("strobe_onehot", n, 1);
      if (freq_wr)      got = {2'd1, wr_ch, wr_data};
      else if (pnum_wr) got = {2'd2, wr_ch, wr_data};
      else begin
        got = {2'd3, 4'd0, 16'd0, start_pulse};
        check("start_bus", {28'd0, wr_ch, wr_data}, 64'd0);
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got=%0h want=none", got);
      end else begin
        check("strobe_seq", got, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_cmd(input logic [3:0] ch, input logic [31:0] f, input logic [31:0] p);
    logic [15:0] oh;
    oh = 16'd1 << ch;
    exp_q.push_back({2'd1, ch, f});
    exp_q.push_back({2'd2, ch, p});
    exp_q.push_back({2'd3, 4'd0, 16'd0, oh});
  endtask

  task automatic push(input logic [3:0] ch, input logic [31:0] f, input logic [31:0] p);
    @(negedge clk100m);
    cmd_valid = 1'b1;
    cmd_ch    = ch;
    cmd_freq  = f;
    cmd_pnum  = p;
    @(posedge clk100m);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk100m);
  endtask

  task automatic wait_idle(input int max, input string name);
    int k;
    k = 0;
    @(negedge clk100m);
    while (!sched_idle && k < max) begin
      @(negedge clk100m);
      k++;
    end
    check(name, sched_idle, 1);
  endtask

  task automatic pulse_abort();
    @(negedge clk100m);
    abort = 1'b1;
    @(posedge clk100m);
    #1 abort = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    cycles(2);
    check("rst_ready", cmd_ready, 1);
    check("rst_idle", sched_idle, 1);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_err", err_tmo, 0);
    check("rst_strobes", {freq_wr, pnum_wr, start_pulse}, 0);
    rst_n = 1'b1;
    cycles(2);

    // Single move, cycle-exact latency.
    expect_cmd(4'd3, 32'h1000, 32'd500);
    push(4'd3, 32'h1000, 32'd500);
    @(negedge clk100m); check("t1_level_e0", fifo_level, 1);
    check("t1_busy_e0", sched_idle, 0);
    @(negedge clk100m); check("t1_check_e1", dbg_state, 1);
    check("t1_nofreq_e1", freq_wr, 0);
    @(negedge clk100m); check("t1_freq_e2", {freq_wr, wr_ch, wr_data}, {1'b1, 4'd3, 32'h1000});
    check("t1_level_e2", fifo_level, 0);
    @(negedge clk100m); check("t1_pnum_e3", {pnum_wr, wr_data}, {1'b1, 32'd500});
    @(negedge clk100m); check("t1_start_e4", start_pulse, 16'h0008);
    @(negedge clk100m); check("t1_wait_e5", sched_idle, 0);
    @(negedge clk100m); check("t1_wait_e6", sched_idle, 0);
    @(negedge clk100m); check("t1_idle_e7", sched_idle, 1);
    cycles(6);

    // Head-of-line blocking preserves order.
    force_busy[5] = 1'b1;
    expect_cmd(4'd5, 32'h5555, 32'd10);
    expect_cmd(4'd2, 32'h2222, 32'd20);
    push(4'd5, 32'h5555, 32'd10);
    push(4'd2, 32'h2222, 32'd20);
    cycles(20);
    check("t2_level_blocked", fifo_level, 2);
    check("t2_no_strobes", exp_q.size(), 6);
    force_busy[5] = 1'b0;
    wait_idle(200, "t2_drain");
    check("t2_all_seen", exp_q.size(), 0);
    cycles(6);

    // Fill the queue, overflow push ignored, then drain in order.
    force_busy = '1;
    for (int i = 0; i < 8; i++) begin
      expect_cmd(4'(i), 32'h100 + 32'(i), 32'(i + 1));
      push(4'(i), 32'h100 + 32'(i), 32'(i + 1));
    end
    @(negedge clk100m);
    check("t3_full_level", fifo_level, 8);
    check("t3_full_ready", cmd_ready, 0);
    push(4'd9, 32'h999, 32'd9);
    @(negedge clk100m);
    check("t3_overflow_level", fifo_level, 8);
    force_busy = '0;
    wait_idle(400, "t3_drain");
    check("t3_all_seen", exp_q.size(), 0);
    check("t3_no_tmo", err_tmo, 0);
    cycles(6);

    // Limit drops are counted; zero pulse count drops silently.
    limit_hit[7] = 1'b1;
    push(4'd7, 32'h71, 32'd1);
    push(4'd7, 32'h72, 32'd2);
    push(4'd7, 32'h73, 32'd3);
    push(4'd4, 32'h44, 32'd0);
    wait_idle(100, "t4_drain");
    check("t4_drop_cnt", drop_cnt, 3);
    check("t4_level", fifo_level, 0);
    limit_hit = '0;
    cycles(2);

    // Start never acknowledged: timeout 16 cycles after the start pulse ends.
    model_en = 1'b0;
    expect_cmd(4'd1, 32'h11, 32'd7);
    push(4'd1, 32'h11, 32'd7);
    cycles(10);
    check("t5_no_tmo_yet", err_tmo, 0);
    k = 0;
    while (!err_tmo && k < 30) begin
      @(negedge clk100m);
      k++;
    end
    check("t5_tmo_set", err_tmo, 1);
    check("t5_tmo_latency", k, 12);
    check("t5_idle_after_tmo", sched_idle, 1);
    pulse_abort();
    @(negedge clk100m);
    check("t5_tmo_cleared", err_tmo, 0);
    model_en = 1'b1;
    cycles(2);

    // Abort during WR_PNUM with four queued; a same-cycle push is ignored.
    force_busy = '1;
    exp_q.push_back({2'd1, 4'd8, 32'h8008});
    exp_q.push_back({2'd2, 4'd8, 32'd80});
    push(4'd8, 32'h8008, 32'd80);
    for (int i = 9; i < 13; i++) push(4'(i), 32'h9000 + 32'(i), 32'(i));
    @(negedge clk100m);
    force_busy = '0;
    k = 0;
    while (!pnum_wr && k < 20) begin
      @(negedge clk100m);
      k++;
    end
    check("t6_reach_pnum", pnum_wr, 1);
    check("t6_level_at_abort", fifo_level, 4);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_ch = 4'd13;
    cmd_pnum = 32'd13;
    #1 check("t6_ready_low", cmd_ready, 0);
    @(posedge clk100m);
    #1 abort = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk100m);
    check("t6_level_flushed", fifo_level, 0);
    check("t6_no_start", start_pulse, 0);
    check("t6_idle", sched_idle, 1);
    cycles(20);
    check("t6_all_seen", exp_q.size(), 0);

    // Reset in the middle of a dispatch.
    force_busy = '1;
    exp_q.push_back({2'd1, 4'd0, 32'hA0A0});
    push(4'd0, 32'hA0A0, 32'd3);
    push(4'd1, 32'h00B1, 32'd4);
    @(negedge clk100m);
    force_busy = '0;
    k = 0;
    while (!freq_wr && k < 20) begin
      @(negedge clk100m);
      k++;
    end
    check("t7_reach_freq", freq_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_strobes", {freq_wr, pnum_wr, start_pulse}, 0);
    check("t7_rst_bus", {wr_ch, wr_data}, 0);
    check("t7_rst_level", fifo_level, 0);
    check("t7_rst_idle", sched_idle, 1);
    check("t7_rst_ready", cmd_ready, 1);
    check("t7_rst_drop", drop_cnt, 0);
    check("t7_rst_err", err_tmo, 0);
    cycles(2);
    rst_n = 1'b1;
    cycles(20);
    check("t7_all_seen", exp_q.size(), 0);
    check("t7_idle_after", sched_idle, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_move_scheduler.md
Name: pwm_move_scheduler

Overview:
- Per-axis move-command scheduler in front of the 16-channel PWM pulse generators.
- Software pushes move commands (channel, frequency word, pulse count) into a shared queue through the AHB register file.
- The block dispatches commands in order: load frequency, load pulse count, then fire a one-hot start, only when the target channel is idle and not at a limit.
- Replaces direct software writes to the freq/pnum/start registers for queued moves.

Parameters:
- NCH, 16, number of PWM channels; cmd_ch width is clog2(NCH).
- DEPTH, 8, command FIFO entries; must be a power of 2.
- ACK_TMO, 16, cycles to wait for the channel busy flag to rise after start.

Ports:
- clk100m  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command push request.
- cmd_ready  out  1  queue can accept a command.
- cmd_ch  in  4  target channel.
- cmd_freq  in  32  frequency word.
- cmd_pnum  in  32  pulse count.
- ch_busy  in  NCH  per-channel running flag (pwm_state_read).
- limit_hit  in  NCH  per-channel limit active (limit_l | limit_r).
- abort  in  1  flush queue and return to idle.
- freq_wr  out  1  one-cycle frequency load strobe.
- pnum_wr  out  1  one-cycle pulse-count load strobe.
- wr_ch  out  4  channel for freq_wr and pnum_wr.
- wr_data  out  32  cmd_freq during freq_wr; cmd_pnum during pnum_wr.
- start_pulse  out  NCH  one-hot, one-cycle start.
- fifo_level  out  clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  commands discarded, saturating.
- err_tmo  out  1  sticky start-acknowledge timeout.
- sched_idle  out  1  FSM in IDLE and FIFO empty.

Behaviour:
Reset (async, rst_n=0):
- FIFO empty; FSM in IDLE.
- All strobes, wr_ch, wr_data, start_pulse, drop_cnt and err_tmo are 0.
- sched_idle=1, cmd_ready=1.

Queue:
- cmd_ready = !full && !abort. It does not look ahead to a same-cycle pop.
- A push occurs on cmd_valid && cmd_ready.
- A simultaneous push and pop leaves the level unchanged.
- The read pointer wraps modulo DEPTH.

FSM (Moore outputs, one state per cycle unless stated):
- IDLE:
  - FIFO not empty -> CHECK.
- CHECK (head command):
  - head pnum==0 -> pop and drop silently (no count) -> IDLE.
  - Otherwise, limit_hit[ch] -> pop, drop_cnt+1 (saturates at 0xFFFF) -> IDLE.
  - Otherwise, ch_busy[ch] -> stay in CHECK. This is head-of-line blocking; order is preserved across all channels.
  - Otherwise -> pop, latch the command -> WR_FREQ.
- WR_FREQ:
  - freq_wr=1, wr_data=freq, wr_ch=ch -> WR_PNUM.
- WR_PNUM:
  - pnum_wr=1, wr_data=pnum -> START.
- START:
  - start_pulse = 1<<ch -> WAIT_ACK.
  - Clear the timeout counter.
- WAIT_ACK:
  - ch_busy[ch]=1 -> IDLE.
  - Counter reaching ACK_TMO-1 -> set err_tmo -> IDLE.

Latency:
- A push accepted at edge E0 into an empty queue with the channel idle gives:
  - CHECK at E1;
  - freq_wr high E2..E3;
  - pnum_wr high E3..E4;
  - start_pulse high E4..E5.

abort (synchronous, highest priority):
- Next edge: FIFO empty, FSM in IDLE, any strobe in flight deasserted, err_tmo cleared.
- A push in the same cycle as abort is ignored.
- A start already issued is not recalled; stopping the channel is software's job via pwm_start_stop.

Other rules:
- Strobes are mutually exclusive.
- wr_data and wr_ch are 0 outside the strobe cycles.
- Reset mid-dispatch discards the latched command with no strobes emitted.

Test Plan:
- Push ch=3, freq=0x1000, pnum=500, ch_busy=0 -> freq_wr at E2 with wr_data=0x1000, pnum_wr at E3 with 500, start_pulse=0x0008 at E4; ch_busy[3] raised at E6 -> sched_idle=1 at E7.
- Push ch=5 then ch=2 with ch_busy[5]=1 for 20 cycles -> no strobes for either; after ch_busy[5] falls, ch5 dispatches before ch2.
- Push 8 commands with ch_busy=all ones -> fifo_level=8, cmd_ready=0; a 9th push is ignored; clear busy -> all 8 start in order.
- limit_hit[7]=1, push 3 commands to ch7 and one with pnum=0 -> drop_cnt=3, no strobes.
- Push ch=1 and never raise ch_busy -> err_tmo=1 16 cycles after start; abort -> err_tmo=0.
- Abort on the WR_PNUM cycle with 4 queued -> no start_pulse, fifo_level=0 next cycle; rst_n low mid-queue -> all outputs at reset values immediately.
